spike_count_decoder: RTL

Output decoder placed directly downstream of the integrate-and-fire network. It takes the network's per-neuron `spike_out` vector and counts the spikes of each output neuron over a programmable window of timesteps. It then scans the counts sequentially to find the neuron that fired most and presents that class index on a valid/ready result interface. This turns the raw spike stream into a classification result for the host or control logic.

---
 rtl/spike_count_decoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spike_count_decoder.sv
// Spike-count output decoder: counts per-neuron spikes over a programmable window,
// then scans the counts sequentially to present the argmax class on a valid/ready port.
module spike_count_decoder #(
  parameter int unsigned NUM_NEURONS  = 1,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter int unsigned WINDOW_WIDTH = 16,
  parameter int unsigned CLASS_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  input  logic [NUM_NEURONS-1:0]  spike_in,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [CLASS_WIDTH-1:0]  result_class,
  output logic [COUNT_WIDTH-1:0]  result_count,
  output logic                    result_tie
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

  state_t                  state, state_next;
  logic [WINDOW_WIDTH-1:0] wlen;
  logic [WINDOW_WIDTH-1:0] tstep;
  logic [COUNT_WIDTH-1:0]  cnt [NUM_NEURONS];
  logic [CLASS_WIDTH-1:0]  scan_idx;
  logic [COUNT_WIDTH-1:0]  sel_count;
  logic [COUNT_WIDTH-1:0]  best_count, best_count_n;
  logic [CLASS_WIDTH-1:0]  best_class, best_class_n;
  logic                    best_tie, best_tie_n;
  logic                    last_step;
  logic                    last_idx;

  assign last_step = (tstep == (wlen - WINDOW_WIDTH'(1)));
  assign last_idx  = (scan_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (window_len != '0) ? COUNT : SCAN;
      COUNT: if (last_step) state_next = SCAN;
      SCAN:  if (last_idx) state_next = DONE;
      DONE:  if (result_valid && result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Select the counter under examination without indexing past the array
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (scan_idx == CLASS_WIDTH'(i)) sel_count = cnt[i];
    end
  end

  // Running argmax; strict greater-than keeps the lowest index on ties
  always_comb begin
    best_count_n = best_count;
    best_class_n = best_class;
    best_tie_n   = best_tie;
    if (scan_idx == '0) begin
      best_count_n = sel_count;
      best_class_n = scan_idx;
      best_tie_n   = 1'b0;
    end else if (sel_count > best_count) begin
      best_count_n = sel_count;
      best_class_n = scan_idx;
      best_tie_n   = 1'b0;
    end else if (sel_count == best_count) begin
      best_tie_n   = 1'b1;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wlen         <= '0;
      tstep        <= '0;
      scan_idx     <= '0;
      best_count   <= '0;
      best_class   <= '0;
      best_tie     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_count <= '0;
      result_tie   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
    end else begin
      busy         <= (state_next != IDLE);
      result_valid <= (state_next == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            wlen       <= window_len;
            tstep      <= '0;
            scan_idx   <= '0;
            best_count <= '0;
            best_class <= '0;
            best_tie   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
          end
        end
        COUNT: begin
          tstep <= tstep + WINDOW_WIDTH'(1);
          for (int i = 0; i < NUM_NEURONS; i++) begin
            if (spike_in[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
          end
        end
        SCAN: begin
          best_count <= best_count_n;
          best_class <= best_class_n;
          best_tie   <= best_tie_n;
          if (last_idx) begin
            result_count <= best_count_n;
            result_class <= best_class_n;
            result_tie   <= best_tie_n;
          end else begin
            scan_idx <= scan_idx + CLASS_WIDTH'(1);
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
